if_id_pipe_reg: RTL and testbench
=================================

# if_id_pipe_reg

Fetch-to-decode pipeline stage. Captures the fetched PC and instruction word from the fetch unit and presents them to decode through a valid/ready handshake. It provides stall (backpressure) and flush (branch/jump redirect) handling, and inserts a NOP bubble whenever the output is not valid. It sits directly downstream of the PC register and instruction memory, and directly upstream of the decoder and register-file read.

## Interface
Parameters:
- N, 32, width of the PC field (XLEN).
- NOP_INSTR, 32'h0000_0013, instruction word driven on out_instr when out_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous squash of all held entries; highest priority.
- in_valid  input  1  fetch offers in_pc/in_instr.
- in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at a rising clk.
- in_pc  input  N  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- out_valid  output  1  out_pc/out_instr hold a live instruction.
- out_ready  input  1  decode consumes; transfer occurs when out_valid && out_ready.
- out_pc  output  N  PC presented to decode.
- out_instr  output  32  instruction presented to decode; NOP_INSTR when out_valid=0.

## Operation
- Two storage slots, main (drives outputs) and skid, are tracked by states EMPTY, ONE and TWO.
- EMPTY: on an accepted input, main loads and the state goes to ONE.
- ONE, input accepted and out_ready=1: main loads the new entry; stay in ONE.
- ONE, input accepted and out_ready=0: skid loads; go to TWO.
- ONE, no input and out_ready=1: go to EMPTY.
- ONE, otherwise: hold.
- TWO: in_ready=0. When out_ready=1, main is loaded from skid and the state goes to ONE. Otherwise hold.
- in_ready = (state != TWO). It comes from the state register only, so there is no combinational path from out_ready to in_ready.
- Order is strictly FIFO. No entry is ever dropped or duplicated except by flush.
- flush=1: the state goes to EMPTY next cycle and both slots are invalidated.
  - An input handshaken in the same cycle counts as consumed and is discarded.
  - An output handshake in the same cycle still counts for decode.
- Outputs when invalid: out_instr = NOP_INSTR and out_pc holds its last value. Only out_valid is meaningful to decode.
- PC width is N bits throughout, with no arithmetic. The instruction is always 32 bits.

## Timing
- Reset values: out_valid=0, out_pc=0, out_instr=NOP_INSTR, state=EMPTY, in_ready=1.
- rst asserted mid-operation clears both slots immediately (asynchronously), regardless of clk.
- Latency: an input accepted at edge k is valid on the outputs after edge k (one cycle).
- Throughput: 1 instruction per cycle when out_ready stays high.
- After a stall releases from TWO, in_ready rises one cycle after the out_ready edge that drains skid.
- With flush and in_valid both asserted in cycle k: out_valid=0 after edge k. The next accepted input appears at k+2 at the earliest.

## Configuration
- IF_ID_SKID_EN defined: the two-slot skid behaviour described above, with registered in_ready.
- IF_ID_SKID_EN undefined: a single slot only; state TWO does not exist.
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Flush, reset values, latency and NOP insertion are unchanged.

## Structure
- Shared package proc_pkg holds:
  - XLEN = 32.
  - NOP_INSTR constant.
  - Stage state enum {EMPTY, ONE, TWO}.
- One sub-module, stage_slot: an N+32-bit storage slot with load enable and asynchronous reset to {0, NOP_INSTR}. It is instantiated as main and skid; skid is omitted without IF_ID_SKID_EN.

## Test plan
- Reset check: assert rst with in_valid=1. Required: out_valid=0, out_instr=32'h13, out_pc=0, in_ready=1 (with SKID).
- Streaming: send pc 0x0,0x4,0x8 with instr 0xA,0xB,0xC and out_ready=1. Required: each appears one cycle later in order, with no bubbles.
- Backpressure: hold out_ready=0 and offer 0x0 and 0x4. Required with SKID: in_ready drops after the second accept; releasing out_ready yields 0x0 then 0x4, with nothing lost or duplicated.
- Flush while in TWO with in_valid=1 (pc 0x8): required next cycle out_valid=0, out_instr=0x13. After flush deasserts, the next input 0x100 emerges and 0x8 never appears.
- Asynchronous reset mid-stream between clock edges: outputs clear immediately. After rst releases, a new input 0x20 appears one cycle after acceptance.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants and the IF/ID stage state type
package proc_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/if_id_pipe_reg_stage_slot.sv
// rtl/if_id_pipe_reg_stage_slot.sv - load-enabled storage slot with async reset value
module stage_slot #(
    parameter int             W       = 64,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - fetch-to-decode stage; IF_ID_SKID_EN selects the two-slot skid variant
module if_id_pipe_reg #(
    parameter int          N         = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_pc,
    input  logic [31:0]  in_instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pc,
    output logic [31:0]  out_instr
);
    import proc_pkg::*;

    localparam int W = N + 32;
    localparam logic [W-1:0] SLOT_RST = {{N{1'b0}}, NOP_INSTR};

    stage_state_e state_q, state_d;
    logic         in_fire;
    logic         main_load;
    logic         main_from_skid;
    logic [W-1:0] main_d, main_q;
    logic [W-1:0] skid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;

`ifdef IF_ID_SKID_EN
    logic skid_load;

    // Registered ready: only the state decides, never out_ready.
    assign in_ready = (state_q != TWO);

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_ready) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_d   = TWO;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush squashes everything; slots keep contents so out_pc holds.
        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    stage_slot #(.W(W), .RST_VAL(SLOT_RST)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    ({in_pc, in_instr}),
        .q    (skid_q)
    );
`else
    assign in_ready = !out_valid || out_ready;
    assign skid_q   = SLOT_RST;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire) begin
                    main_load = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d   = EMPTY;
            main_load = 1'b0;
        end
    end
`endif

    assign main_d = main_from_skid ? skid_q : {in_pc, in_instr};

    stage_slot #(.W(W), .RST_VAL(SLOT_RST)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    assign out_pc    = main_q[W-1:32];
    assign out_instr = out_valid ? main_q[31:0] : NOP_INSTR;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - scoreboard bench for if_id_pipe_reg (either IF_ID_SKID_EN build)
module tb_if_id_pipe_reg;

    localparam int N = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_pc = '0;
    logic [31:0]  in_instr = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_pc;
    logic [31:0]  out_instr;

    int n_cmp = 0;
    int n_err = 0;

    logic [N+31:0] sb[$];
    logic [N-1:0]  last_pc = '0;

    always #5 clk = ~clk;

    if_id_pipe_reg #(.N(N), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

    function automatic logic model_ready(input logic ordy);
`ifdef IF_ID_SKID_EN
        return sb.size() < 2;
`else
        return (sb.size() == 0) || ordy;
`endif
    endfunction

    // One cycle: drive at negedge, compare, then advance the model as the edge will.
    task automatic step(input logic iv, input logic [N-1:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, output logic accepted);
        logic exp_rdy;
        logic exp_vld;
        @(negedge clk);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = model_ready(ordy);
        exp_vld = (sb.size() != 0);
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b want %b (t=%0t)", in_ready, exp_rdy, $time);
        end
        n_cmp++;
        if (out_valid !== exp_vld) begin
            n_err++;
            $display("FAIL out_valid: got %b want %b (t=%0t)", out_valid, exp_vld, $time);
        end
        if (exp_vld) begin
            last_pc = sb[0][N+31:32];
            n_cmp++;
            if ({out_pc, out_instr} !== sb[0]) begin
                n_err++;
                $display("FAIL out_data: got pc=%h instr=%h want pc=%h instr=%h (t=%0t)",
                         out_pc, out_instr, sb[0][N+31:32], sb[0][31:0], $time);
            end
        end else begin
            n_cmp++;
            if ({out_pc, out_instr} !== {last_pc, NOP}) begin
                n_err++;
                $display("FAIL bubble: got pc=%h instr=%h want pc=%h instr=%h (t=%0t)",
                         out_pc, out_instr, last_pc, NOP, $time);
            end
        end
        accepted = iv && exp_rdy;
        if (exp_vld && ordy) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (accepted) sb.push_back({pc, ins});
    endtask

    task automatic send(input logic [N-1:0] pc, input logic [31:0] ins, input logic ordy);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            step(1'b1, pc, ins, ordy, 1'b0, acc);
            tries++;
        end
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_timeout: pc=%h never accepted", pc);
        end
    endtask

    task automatic idle(input logic ordy, input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, ordy, 1'b0, acc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'hDEAD_BEEF;
        in_instr = 32'h1234_5678;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_pc, out_instr, in_ready} !== {1'b0, 32'h0, NOP, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b pc=%h instr=%h rdy=%b want v=0 pc=0 instr=%h rdy=1",
                     out_valid, out_pc, out_instr, in_ready, NOP);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        sb.delete();
        last_pc = '0;
    endtask

    task automatic test_streaming();
        logic acc;
        step(1'b1, 32'h0, 32'hA, 1'b1, 1'b0, acc);
        step(1'b1, 32'h4, 32'hB, 1'b1, 1'b0, acc);
        step(1'b1, 32'h8, 32'hC, 1'b1, 1'b0, acc);
        idle(1'b1, 2);
    endtask

    task automatic test_backpressure();
        logic acc;
        step(1'b1, 32'h0, 32'hA, 1'b0, 1'b0, acc);
        step(1'b1, 32'h4, 32'hB, 1'b0, 1'b0, acc);
        if (!acc) send(32'h4, 32'hB, 1'b1);
        step(1'b1, 32'h8, 32'hC, 1'b0, 1'b0, acc);
        if (acc) idle(1'b1, 1);
        idle(1'b0, 1);
        idle(1'b1, 4);
    endtask

    task automatic test_flush();
        logic acc;
        step(1'b1, 32'h40, 32'h1111, 1'b0, 1'b0, acc);
        step(1'b1, 32'h44, 32'h2222, 1'b0, 1'b0, acc);
        step(1'b1, 32'h8, 32'hC, 1'b0, 1'b1, acc);
        idle(1'b1, 1);
        send(32'h100, 32'h3333, 1'b1);
        idle(1'b1, 2);
        step(1'b1, 32'h200, 32'h4444, 1'b1, 1'b1, acc);
        idle(1'b1, 2);
    endtask

    task automatic test_async_reset();
        logic acc;
        step(1'b1, 32'h50, 32'h5555, 1'b0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_pc, out_instr} !== {1'b0, 32'h0, NOP}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b pc=%h instr=%h want v=0 pc=0 instr=%h",
                     out_valid, out_pc, out_instr, NOP);
        end
        sb.delete();
        last_pc = '0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        send(32'h20, 32'h6666, 1'b1);
        idle(1'b1, 2);
    endtask

    task automatic test_back_to_back();
        logic acc;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), N'($urandom), $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), acc);
        end
        idle(1'b1, 3);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
